pipe_stage_chain: RTL and testbench
===================================

PIPE_STAGE_CHAIN -- requirements
Module: pipe_stage_chain

Interface
REQ-001 Parameter WIDTH, default 32: payload width in bits (legal 1..128).
REQ-002 Parameter DEPTH, default 4: number of register stages (legal 1..8).
REQ-003 Parameter CNT_W, default 16: width of the drop counter.
REQ-004 clk  input  1: single clock; all state updates on rising edge.
REQ-005 reset  input  1: asynchronous, active-high reset.
REQ-006 in_valid  input  1: upstream offers in_data this cycle.
REQ-007 in_data  input  WIDTH: payload (IR/PC/control bundle).
REQ-008 in_ready  output  1: chain accepts in_data this cycle.
REQ-009 out_valid  output  1: last stage holds a live item.
REQ-010 out_data  output  WIDTH: payload of last stage.
REQ-011 out_ready  input  1: downstream consumes out_data this cycle.
REQ-012 flush  input  DEPTH: bit i kills the item in stage i (bit 0 = youngest).
REQ-013 stage_valid  output  DEPTH: registered valid bit of each stage.
REQ-014 occupancy  output  clog2(DEPTH+1): registered count of valid stages.
REQ-015 drop_count  output  CNT_W: saturating count of items killed by flush.

Function
REQ-016 Stage i is live when valid[i]=1 and flush[i]=0.
REQ-017 Last stage advances when live and out_ready=1; out_valid = live(DEPTH-1), combinational.
REQ-018 Stage i (i<DEPTH-1) transfers to stage i+1 when live and stage i+1 can load.
REQ-019 Stage j can load when valid[j]=0, or flush[j]=1, or stage j advances this cycle (bubble collapse).
REQ-020 in_ready = stage 0 can load; combinational, no dependency on in_valid.
REQ-021 Input handshake completes when in_valid & in_ready; item enters stage 0 at that edge.
REQ-022 Per stage next valid: 1 if loading, else 0 if flushed or advancing, else hold.
REQ-023 Data register of a stage updates only when it loads; otherwise holds (including when emptied).
REQ-024 Latency: an item accepted at edge N with no backpressure is presented on out_data after edge N+DEPTH-1 (DEPTH cycles of register delay, first visible cycle after edge N+DEPTH-1).
REQ-025 Throughput: one item per cycle when out_ready stays 1; no bubbles inserted.
REQ-026 Order preserved; no item duplicated or lost except by flush.
REQ-027 flush[i] on an empty stage has no effect and does not count as a drop.
REQ-028 Flushed stage may load a new item in the same cycle (flush kills old occupant only).
REQ-029 in_data presented in a cycle where flush[0]=1 is still accepted if in_ready=1.
REQ-030 occupancy = popcount of next valid vector, registered with valid.
REQ-031 drop_count increments by popcount(flush & valid) each edge; saturates at all-ones, never wraps.
REQ-032 Full (all valid, out_ready=0, flush=0): in_ready=0, all stages hold.
REQ-033 Empty: out_valid=0, in_ready=1.

Reset
REQ-034 reset=1 clears all valid bits, data registers, occupancy and drop_count to 0 immediately, independent of clk.
REQ-035 Reset mid-operation discards all in-flight items without counting them as drops.
REQ-036 After reset deasserts, first item may be accepted on the next rising edge.

Structure
REQ-037 Shared package holds max DEPTH/WIDTH constants and the popcount function.
REQ-038 One sub-module, pipe_stage_cell (valid + data register with load/kill), instantiated DEPTH times via generate.
REQ-039 Top-level ready chain computed from last stage to first in combinational logic.

Verification
REQ-040 DEPTH=4, stream 0x1..0x8 with out_ready=1 -> out_data 0x1..0x8 on consecutive cycles, first after 4 edges.
REQ-041 Fill 4 items, out_ready=0 -> in_ready=0, occupancy=4; release out_ready -> items drain in order.
REQ-042 Items 0xA,0xB in stages 0,2, out_ready=0 -> 0xA collapses forward to stage 1 next edge.
REQ-043 Full chain, flush=4'b0110 -> drop_count +2, occupancy=2, survivors exit in order.
REQ-044 CNT_W=2, flush live stages repeatedly -> drop_count sticks at 3.
REQ-045 Assert reset between edges with 3 items in flight -> stage_valid=0, occupancy=0, drop_count unchanged at 0 immediately.

Source files
------------

// File: rtl/pipe_stage_chain_pkg.sv
// Shared constants and helpers for the pipe_stage_chain register pipeline.
// Callers pass valid/flush vectors zero-padded to MaxDepth bits.
package pipe_stage_chain_pkg;

    localparam int unsigned MaxDepth = 8;
    localparam int unsigned MaxWidth = 128;
    localparam int unsigned PopW     = $clog2(MaxDepth + 1);

    function automatic logic [PopW-1:0] popcount(input logic [MaxDepth-1:0] v);
        logic [PopW-1:0] n;
        n = '0;
        for (int i = 0; i < int'(MaxDepth); i++) begin
            n = n + PopW'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/pipe_stage_chain_cell.sv
// One pipeline stage: valid bit plus payload register with load/kill control.
// Load wins over kill so a flushed stage can take a new occupant in the same cycle.
module pipe_stage_cell #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             kill_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic             next_valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (kill_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o      = valid_q;
    assign next_valid_o = valid_d;
    assign data_o       = data_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// Elastic register chain with per-stage flush, bubble collapse and a saturating drop counter.
// Ready propagates combinationally from the last stage back to stage 0.
module pipe_stage_chain
    import pipe_stage_chain_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    input  logic [DEPTH-1:0]           flush,
    output logic [DEPTH-1:0]           stage_valid,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [CNT_W-1:0]           drop_count
);

    localparam int unsigned OccW = $clog2(DEPTH + 1);
    localparam int unsigned SumW = CNT_W + PopW;

    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] valid_nxt;
    logic [DEPTH-1:0] live;
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] can_load;
    logic [DEPTH-1:0] load;
    logic [DEPTH-1:0] kill;
    logic [WIDTH-1:0] data [DEPTH];

    // Walk from the oldest stage back so each can_load sees its successor's decision.
    always_comb begin
        live     = valid & ~flush;
        adv      = '0;
        can_load = '0;
        adv[DEPTH-1]      = live[DEPTH-1] & out_ready;
        can_load[DEPTH-1] = ~valid[DEPTH-1] | flush[DEPTH-1] | adv[DEPTH-1];
        for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
            adv[i]      = live[i] & can_load[i+1];
            can_load[i] = ~valid[i] | flush[i] | adv[i];
        end
        load    = '0;
        load[0] = in_valid & can_load[0];
        for (int i = 1; i < int'(DEPTH); i++) begin
            load[i] = adv[i-1];
        end
        kill = flush | adv;
    end

    for (genvar g = 0; g < int'(DEPTH); g++) begin : g_stage
        logic [WIDTH-1:0] din;
        if (g == 0) begin : g_head
            assign din = in_data;
        end else begin : g_body
            assign din = data[g-1];
        end
        pipe_stage_cell #(
            .WIDTH(WIDTH)
        ) u_cell (
            .clk         (clk),
            .reset       (reset),
            .load_i      (load[g]),
            .kill_i      (kill[g]),
            .data_i      (din),
            .valid_o     (valid[g]),
            .next_valid_o(valid_nxt[g]),
            .data_o      (data[g])
        );
    end

    logic [OccW-1:0]     occ_q, occ_d;
    logic [CNT_W-1:0]    drop_q, drop_d;
    logic [MaxDepth-1:0] nv_pad;
    logic [MaxDepth-1:0] dv_pad;
    logic [SumW-1:0]     drop_sum;

    always_comb begin
        nv_pad             = '0;
        nv_pad[DEPTH-1:0]  = valid_nxt;
        dv_pad             = '0;
        dv_pad[DEPTH-1:0]  = flush & valid;
        occ_d              = OccW'(popcount(nv_pad));
        drop_sum           = {{PopW{1'b0}}, drop_q} + SumW'(popcount(dv_pad));
        drop_d             = (|drop_sum[SumW-1:CNT_W]) ? '1 : drop_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q  <= '0;
            drop_q <= '0;
        end else begin
            occ_q  <= occ_d;
            drop_q <= drop_d;
        end
    end

    assign in_ready    = can_load[0];
    assign out_valid   = live[DEPTH-1];
    assign out_data    = data[DEPTH-1];
    assign stage_valid = valid;
    assign occupancy   = occ_q;
    assign drop_count  = drop_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain: slot-moving reference model plus directed literal checks.
module tb_pipe_stage_chain;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b0;
    logic [3:0]  flush = '0;

    logic        in_ready1, out_valid1, in_ready2, out_valid2;
    logic [31:0] out_data1, out_data2;
    logic [3:0]  stage_valid1, stage_valid2;
    logic [2:0]  occ1, occ2;
    logic [15:0] drop1;
    logic [1:0]  drop2;

    int n_pass = 0;
    int n_total = 0;

    // Reference state: which slots hold an item, what each data register holds, drops so far.
    bit   [3:0]       mv;
    logic [3:0][31:0] md;
    int               mdrops;

    pipe_stage_chain #(.WIDTH(32), .DEPTH(4), .CNT_W(16)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready1), .out_valid(out_valid1), .out_data(out_data1),
        .out_ready(out_ready), .flush(flush), .stage_valid(stage_valid1),
        .occupancy(occ1), .drop_count(drop1)
    );

    pipe_stage_chain #(.WIDTH(32), .DEPTH(4), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready2), .out_valid(out_valid2), .out_data(out_data2),
        .out_ready(out_ready), .flush(flush), .stage_valid(stage_valid2),
        .occupancy(occ2), .drop_count(drop2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    // Items move toward the output one slot per cycle whenever the slot ahead ends up free.
    task automatic model_plan(output bit [3:0] nv, output logic [3:0][31:0] nd,
                              output bit rdy, output int ndrop);
        nd    = md;
        nv    = '0;
        ndrop = mdrops;
        for (int i = 0; i < 4; i++) if (mv[i] && flush[i]) ndrop++;
        for (int i = 3; i >= 0; i--) begin
            if (mv[i] && !flush[i]) begin
                if (i == 3) begin
                    if (!out_ready) nv[3] = 1'b1;
                end else if (!nv[i+1]) begin
                    nv[i+1] = 1'b1;
                    nd[i+1] = md[i];
                end else begin
                    nv[i] = 1'b1;
                end
            end
        end
        rdy = !nv[0];
        if (rdy && in_valid) begin
            nv[0] = 1'b1;
            nd[0] = in_data;
        end
    endtask

    task automatic model_reset();
        mv     = '0;
        md     = '0;
        mdrops = 0;
    endtask

    task automatic model_step();
        bit   [3:0]       nv;
        logic [3:0][31:0] nd;
        bit               rdy;
        int               ndrop;
        if (reset) begin
            model_reset();
        end else begin
            model_plan(nv, nd, rdy, ndrop);
            mv     = nv;
            md     = nd;
            mdrops = ndrop;
        end
    endtask

    always @(negedge clk) begin
        bit   [3:0]       nv;
        logic [3:0][31:0] nd;
        bit               rdy;
        int               ndrop;
        model_plan(nv, nd, rdy, ndrop);
        chk("in_ready", 64'(in_ready1), 64'(rdy));
        chk("out_valid", 64'(out_valid1), 64'(mv[3] & ~flush[3]));
        chk("out_data", 64'(out_data1), 64'(md[3]));
        chk("stage_valid", 64'(stage_valid1), 64'(mv));
        chk("occupancy", 64'(occ1), 64'($countones(mv)));
        chk("drop_count", 64'(drop1), 64'(sat(mdrops, 65535)));
        chk("drop_count_w2", 64'(drop2), 64'(sat(mdrops, 3)));
        chk("stage_valid_w2", 64'(stage_valid2), 64'(mv));
    end

    task automatic drive(input bit v, input logic [31:0] d, input bit r, input logic [3:0] f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic cycle(input bit v, input logic [31:0] d, input bit r, input logic [3:0] f);
        drive(v, d, r, f);
        tick();
    endtask

    typedef struct packed {
        bit          v;
        logic [31:0] d;
        bit          r;
        logic [3:0]  f;
    } vec_t;

    vec_t mix [10];

    initial begin
        mix[0] = '{1'b1, 32'h50, 1'b1, 4'b0000};
        mix[1] = '{1'b1, 32'h51, 1'b0, 4'b0000};
        mix[2] = '{1'b1, 32'h52, 1'b0, 4'b0010};
        mix[3] = '{1'b1, 32'h53, 1'b0, 4'b0001};
        mix[4] = '{1'b0, 32'h00, 1'b0, 4'b0000};
        mix[5] = '{1'b1, 32'h54, 1'b0, 4'b0000};
        mix[6] = '{1'b1, 32'h55, 1'b0, 4'b1000};
        mix[7] = '{1'b1, 32'h56, 1'b1, 4'b0100};
        mix[8] = '{1'b0, 32'h00, 1'b1, 4'b1111};
        mix[9] = '{1'b1, 32'h57, 1'b1, 4'b0000};

        model_reset();
        #1 reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_stage_valid", 64'(stage_valid1), 64'h0);
        chk("rst_occupancy", 64'(occ1), 64'h0);
        chk("rst_empty_in_ready", 64'(in_ready1), 64'h1);
        chk("rst_empty_out_valid", 64'(out_valid1), 64'h0);

        // Back-to-back stream: first result visible after four edges, then one per cycle.
        for (int k = 1; k <= 11; k++) begin
            cycle(k <= 8, 32'(k), 1'b1, 4'b0000);
            if (k >= 4) begin
                chk("stream_out_data", 64'(out_data1), 64'(k - 3));
                chk("stream_out_valid", 64'(out_valid1), 64'h1);
            end
        end
        cycle(1'b0, 32'h0, 1'b1, 4'b0000);

        // Fill under backpressure, then drain in order.
        for (int k = 0; k < 4; k++) cycle(1'b1, 32'h11 + 32'(k), 1'b0, 4'b0000);
        chk("full_occupancy", 64'(occ1), 64'h4);
        chk("full_stage_valid", 64'(stage_valid1), 64'hf);
        drive(1'b1, 32'h15, 1'b0, 4'b0000);
        #1 chk("full_in_ready", 64'(in_ready1), 64'h0);
        tick();
        chk("full_hold_stage_valid", 64'(stage_valid1), 64'hf);
        chk("full_hold_out_data", 64'(out_data1), 64'h11);
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 32'h0, 1'b1, 4'b0000);
            #1 chk("drain_out_data", 64'(out_data1), 64'h11 + 64'(k));
            tick();
        end
        chk("drained_stage_valid", 64'(stage_valid1), 64'h0);

        // Build 0x9@s3, 0xB@s2, 0xA@s0 with a hole at s1.
        cycle(1'b1, 32'h9, 1'b0, 4'b0000);
        cycle(1'b0, 32'h0, 1'b0, 4'b0000);
        cycle(1'b1, 32'hB, 1'b0, 4'b0000);
        cycle(1'b0, 32'h0, 1'b0, 4'b0000);
        cycle(1'b1, 32'hA, 1'b0, 4'b0000);
        chk("hole_stage_valid", 64'(stage_valid1), 64'hd);
        cycle(1'b0, 32'h0, 1'b0, 4'b0000);
        chk("collapse_stage_valid", 64'(stage_valid1), 64'he);
        chk("collapse_occupancy", 64'(occ1), 64'h3);

        // Fill to full, then flush the middle two stages.
        cycle(1'b1, 32'hC, 1'b0, 4'b0000);
        chk("refill_stage_valid", 64'(stage_valid1), 64'hf);
        cycle(1'b0, 32'h0, 1'b0, 4'b0110);
        chk("flush_drop_count", 64'(drop1), 64'h2);
        chk("flush_occupancy", 64'(occ1), 64'h2);
        chk("flush_stage_valid", 64'(stage_valid1), 64'ha);
        drive(1'b0, 32'h0, 1'b1, 4'b0000);
        #1 chk("survivor0", 64'(out_data1), 64'h9);
        tick();
        tick();
        chk("survivor1", 64'(out_data1), 64'hC);
        chk("survivor1_valid", 64'(out_valid1), 64'h1);
        tick();

        // Repeated stage-0 kills while new items load; flush of empty s3 must not count.
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, 32'h20 + 32'(k), 1'b1, (k == 0) ? 4'b1000 : 4'b1001);
        end
        chk("sat_drop_w16", 64'(drop1), 64'h6);
        chk("sat_drop_w2", 64'(drop2), 64'h3);
        chk("sat_stage_valid", 64'(stage_valid1), 64'h1);

        // Asynchronous reset with three items in flight.
        cycle(1'b1, 32'h30, 1'b0, 4'b0000);
        cycle(1'b1, 32'h31, 1'b0, 4'b0000);
        chk("inflight_occupancy", 64'(occ1), 64'h3);
        drive(1'b0, 32'h0, 1'b0, 4'b0000);
        #2 reset = 1'b1;
        model_reset();
        #1;
        chk("async_rst_stage_valid", 64'(stage_valid1), 64'h0);
        chk("async_rst_occupancy", 64'(occ1), 64'h0);
        chk("async_rst_drop_count", 64'(drop1), 64'h0);
        tick();
        reset = 1'b0;
        cycle(1'b1, 32'h40, 1'b1, 4'b0000);
        chk("post_rst_accept", 64'(stage_valid1), 64'h1);

        for (int k = 0; k < 10; k++) cycle(mix[k].v, mix[k].d, mix[k].r, mix[k].f);
        for (int k = 0; k < 6; k++) cycle(1'b0, 32'h0, 1'b1, 4'b0000);
        chk("final_empty", 64'(stage_valid1), 64'h0);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
